// File: rtl/bcd_addsub_seq_ctrl_if.sv
// Operand request / result bundle for the BCD add/subtract sequencer.
interface bcd_addsub_seq_ctrl_if #(parameter int NDIG = 3);
   logic              start;
   logic              op;
   logic              sign_a;
   logic [4*NDIG-1:0] a_bcd;
   logic              sign_b;
   logic [4*NDIG-1:0] b_bcd;
   logic              busy;
   logic              done;
   logic              res_sign;
   logic [4*NDIG-1:0] res_bcd;
   logic              ovf;
   logic              err;

   modport slave (
      input  start, op, sign_a, a_bcd, sign_b, b_bcd,
      output busy, done, res_sign, res_bcd, ovf, err
   );

   modport master (
      output start, op, sign_a, a_bcd, sign_b, b_bcd,
      input  busy, done, res_sign, res_bcd, ovf, err
   );
endinterface

// File: rtl/bcd_addsub_seq_ctrl.sv
// Signed sign-magnitude BCD add/subtract sequencer driving one shared external digit adder.
// Optional LED segment output is enabled with `define BCD_ADDSUB_SEQ_LED_EN.
module bcd_addsub_seq_ctrl #(
   parameter int NDIG = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   bcd_addsub_seq_ctrl_if.slave   bus,
   output logic [3:0]             dig_a,
   output logic [3:0]             dig_b,
   output logic                   dig_cin,
   input  logic [3:0]             dig_sum,
   input  logic                   dig_cout
`ifdef BCD_ADDSUB_SEQ_LED_EN
   ,
   output logic [7*(NDIG+1)-1:0]  seg
`endif
);

   localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef logic [NDIG-1:0][3:0] bcd_t;
   typedef enum logic [1:0] {S_IDLE, S_PASS1, S_RECOMP, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic            carry_q, carry_d;
   logic            eff_q, eff_d;
   logic            sign_a_q, sign_a_d;
   bcd_t            a_q, a_d;
   bcd_t            b_q, b_d;
   bcd_t            work_q, work_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            res_sign_q, res_sign_d;
   bcd_t            res_bcd_q, res_bcd_d;
   logic            ovf_q, ovf_d;
   logic            err_q, err_d;

   function automatic logic has_bad_digit(input bcd_t v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (v[i] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   // Subtraction adds the 9's complement of B with carry-in 1 (10's complement).
   always_comb begin
      dig_a   = 4'd0;
      dig_b   = 4'd0;
      dig_cin = 1'b0;
      case (state_q)
         S_PASS1: begin
            dig_a   = a_q[k_q];
            dig_b   = eff_q ? (4'd9 - b_q[k_q]) : b_q[k_q];
            dig_cin = carry_q;
         end
         S_RECOMP: begin
            dig_a   = 4'd9 - work_q[k_q];
            dig_b   = 4'd0;
            dig_cin = carry_q;
         end
         default: ;
      endcase
   end

   bcd_t work_upd;
   logic last_dig;
   logic fin;
   bcd_t fin_bcd;
   logic fin_sign;
   logic fin_ovf;

   always_comb begin
      work_upd        = work_q;
      work_upd[k_q]   = dig_sum;
      last_dig        = (k_q == KW'(NDIG - 1));

      state_d    = state_q;
      k_d        = k_q;
      carry_d    = carry_q;
      eff_d      = eff_q;
      sign_a_d   = sign_a_q;
      a_d        = a_q;
      b_d        = b_q;
      work_d     = work_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      res_sign_d = res_sign_q;
      res_bcd_d  = res_bcd_q;
      ovf_d      = ovf_q;
      err_d      = err_q;
      fin        = 1'b0;
      fin_bcd    = work_upd;
      fin_sign   = sign_a_q;
      fin_ovf    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               a_d        = bus.a_bcd;
               b_d        = bus.b_bcd;
               sign_a_d   = bus.sign_a;
               eff_d      = bus.op ^ bus.sign_a ^ bus.sign_b;
               carry_d    = bus.op ^ bus.sign_a ^ bus.sign_b;
               k_d        = '0;
               work_d     = '0;
               busy_d     = 1'b1;
               res_sign_d = 1'b0;
               res_bcd_d  = '0;
               ovf_d      = 1'b0;
               err_d      = 1'b0;
               if (has_bad_digit(bus.a_bcd) || has_bad_digit(bus.b_bcd)) begin
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_PASS1;
               end
            end
         end
         S_PASS1: begin
            work_d  = work_upd;
            carry_d = dig_cout;
            k_d     = k_q + 1'b1;
            if (last_dig) begin
               k_d = '0;
               if (!eff_q) begin
                  fin     = 1'b1;
                  fin_ovf = dig_cout;
               end else if (dig_cout) begin
                  fin     = 1'b1;
               end else begin
                  // Raw difference went negative: recomplement to get the magnitude.
                  carry_d = 1'b1;
                  state_d = S_RECOMP;
               end
            end
         end
         S_RECOMP: begin
            work_d  = work_upd;
            carry_d = dig_cout;
            k_d     = k_q + 1'b1;
            if (last_dig) begin
               k_d      = '0;
               fin      = 1'b1;
               fin_sign = ~sign_a_q;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (fin) begin
         state_d    = S_DONE;
         done_d     = 1'b1;
         res_bcd_d  = fin_bcd;
         res_sign_d = fin_sign & (|fin_bcd);
         ovf_d      = fin_ovf;
      end
   end

`ifdef BCD_ADDSUB_SEQ_LED_EN
   logic [7*(NDIG+1)-1:0] seg_q, seg_d;

   // Segment order {a,b,c,d,e,f,g}, a in the MSB.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0: s = 7'b1111110;
         4'd1: s = 7'b0110000;
         4'd2: s = 7'b1101101;
         4'd3: s = 7'b1111001;
         4'd4: s = 7'b0110011;
         4'd5: s = 7'b1011011;
         4'd6: s = 7'b1011111;
         4'd7: s = 7'b1110000;
         4'd8: s = 7'b1111111;
         4'd9: s = 7'b1111011;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   always_comb begin
      seg_d = seg_q;
      if (state_q == S_DONE) begin
         for (int i = 0; i < NDIG; i++) seg_d[7*i +: 7] = seg7(res_bcd_q[i]);
         seg_d[7*NDIG +: 7] = {6'b000000, res_sign_q};
      end
   end

   assign seg = seg_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         k_q        <= '0;
         carry_q    <= 1'b0;
         eff_q      <= 1'b0;
         sign_a_q   <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         work_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         res_sign_q <= 1'b0;
         res_bcd_q  <= '0;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
`ifdef BCD_ADDSUB_SEQ_LED_EN
         seg_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         carry_q    <= carry_d;
         eff_q      <= eff_d;
         sign_a_q   <= sign_a_d;
         a_q        <= a_d;
         b_q        <= b_d;
         work_q     <= work_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         res_sign_q <= res_sign_d;
         res_bcd_q  <= res_bcd_d;
         ovf_q      <= ovf_d;
         err_q      <= err_d;
`ifdef BCD_ADDSUB_SEQ_LED_EN
         seg_q      <= seg_d;
`endif
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.res_sign = res_sign_q;
   assign bus.res_bcd  = res_bcd_q;
   assign bus.ovf      = ovf_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_bcd_addsub_seq_ctrl.sv
// Bench for bcd_addsub_seq_ctrl: integer-arithmetic reference model, per-cycle compare, directed cases.
module tb_bcd_addsub_seq_ctrl;
   localparam int NDIG = 3;
   localparam int W    = 4 * NDIG;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bcd_addsub_seq_ctrl_if #(.NDIG(NDIG)) bus ();

   logic [3:0] dig_a, dig_b, dig_sum;
   logic       dig_cin, dig_cout;

   function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b, input logic c);
      int s;
      s = int'(a) + int'(b) + int'(c);
      if (s > 9) return {1'b1, 4'(s - 10)};
      return {1'b0, 4'(s)};
   endfunction

   assign {dig_cout, dig_sum} = bcd_digit_add(dig_a, dig_b, dig_cin);

`ifdef BCD_ADDSUB_SEQ_LED_EN
   logic [7*(NDIG+1)-1:0] seg;
`endif

   bcd_addsub_seq_ctrl #(.NDIG(NDIG)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .dig_a    (dig_a),
      .dig_b    (dig_b),
      .dig_cin  (dig_cin),
      .dig_sum  (dig_sum),
      .dig_cout (dig_cout)
`ifdef BCD_ADDSUB_SEQ_LED_EN
      ,
      .seg      (seg)
`endif
   );

   int checks   = 0;
   int failures = 0;
   int edges    = 0;

   always @(posedge clk) edges <= edges + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @edge %0d: got 0x%0h want 0x%0h", nm, edges, act, exp);
      end
   endtask

   // Reference model state: r_* = result of the op in flight, h_* = values held before it.
   int                    t0     = 0;
   int                    lat    = 0;
   int                    rst_at = 1;
   logic                  r_sign = 1'b0, r_ovf = 1'b0, r_err = 1'b0, r_eff = 1'b0;
   logic [W-1:0]          r_bcd  = '0;
   logic [NDIG-1:0][3:0]  r_a    = '0;
   logic [NDIG-1:0][3:0]  r_b    = '0;
   logic                  h_sign = 1'b0, h_ovf = 1'b0, h_err = 1'b0;
   logic [W-1:0]          h_bcd  = '0;

   function automatic int bcd2int(input logic [W-1:0] v);
      int n;
      n = 0;
      for (int i = NDIG - 1; i >= 0; i--) n = n * 10 + int'(v[4*i +: 4]);
      return n;
   endfunction

   function automatic logic [W-1:0] int2bcd(input int n);
      logic [W-1:0] v;
      int m;
      v = '0;
      m = n;
      for (int i = 0; i < NDIG; i++) begin
         v[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return v;
   endfunction

   function automatic logic [6:0] led_digit(input int d);
      case (d)
         0: return 7'h7E;  1: return 7'h30;  2: return 7'h6D;  3: return 7'h79;
         4: return 7'h33;  5: return 7'h5B;  6: return 7'h5F;  7: return 7'h70;
         8: return 7'h7F;  9: return 7'h7B;
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [31:0] led_word(input logic [W-1:0] v, input logic s);
      logic [31:0] w;
      w = 32'(s) << (7 * NDIG);
      for (int i = 0; i < NDIG; i++) w = w | (32'(led_digit(int'(v[4*i +: 4]))) << (7 * i));
      return w;
   endfunction

   task automatic chk_outs(input string tag, input logic bsy, input logic dn, input logic [W-1:0] rb,
                           input logic rs, input logic ov, input logic er);
      chk({tag, "_busy"}, 32'(bus.busy), 32'(bsy));
      chk({tag, "_done"}, 32'(bus.done), 32'(dn));
      chk({tag, "_res_bcd"}, 32'(bus.res_bcd), 32'(rb));
      chk({tag, "_res_sign"}, 32'(bus.res_sign), 32'(rs));
      chk({tag, "_ovf"}, 32'(bus.ovf), 32'(ov));
      chk({tag, "_err"}, 32'(bus.err), 32'(er));
   endtask

   task automatic chk_dig_idle(input string tag);
      chk({tag, "_dig_a"}, 32'(dig_a), 32'd0);
      chk({tag, "_dig_b"}, 32'(dig_b), 32'd0);
      chk({tag, "_dig_cin"}, 32'(dig_cin), 32'd0);
   endtask

   always @(negedge clk) begin : cmp
      automatic int e;
      if (edges >= 1) begin
         e = edges - t0;
         if (rst_at > 0 && edges >= rst_at) begin
            chk_outs("rst", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
            chk_dig_idle("rst");
`ifdef BCD_ADDSUB_SEQ_LED_EN
            chk("rst_seg", 32'(seg), 32'd0);
`endif
         end else if (e <= 0) begin
            chk_outs("hold", 1'b0, 1'b0, h_bcd, h_sign, h_ovf, h_err);
            chk_dig_idle("hold");
         end else if (e < lat) begin
            chk_outs("run", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
            if (e <= NDIG) begin
               chk("p1_dig_a", 32'(dig_a), 32'(r_a[e-1]));
               chk("p1_dig_b", 32'(dig_b), 32'(r_eff ? (4'd9 - r_b[e-1]) : r_b[e-1]));
               if (e == 1) chk("p1_cin0", 32'(dig_cin), 32'(r_eff));
            end else if (e == NDIG + 1) begin
               chk("rc_dig_b", 32'(dig_b), 32'd0);
               chk("rc_cin0", 32'(dig_cin), 32'd1);
            end
         end else begin
            chk_outs((e == lat) ? "done" : "after", e == lat, e == lat, r_bcd, r_sign, r_ovf, r_err);
            chk_dig_idle("done");
`ifdef BCD_ADDSUB_SEQ_LED_EN
            if (e > lat) chk("seg", 32'(seg), led_word(r_bcd, r_sign));
`endif
         end
      end
   end

   task automatic run_op(input logic op, input logic sa, input logic [W-1:0] a,
                         input logic sb, input logic [W-1:0] b, input bit poke, input int rst_e);
      int  va, vb, r, s, mag;
      bit  bad;
      @(negedge clk);
      if (rst_at > 0) begin
         h_bcd = '0; h_sign = 1'b0; h_ovf = 1'b0; h_err = 1'b0;
      end else begin
         h_bcd = r_bcd; h_sign = r_sign; h_ovf = r_ovf; h_err = r_err;
      end
      t0     = edges;
      rst_at = 0;

      bad = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      r_a   = a;
      r_b   = b;
      r_eff = op ^ sa ^ sb;
      if (bad) begin
         r_bcd = '0; r_sign = 1'b0; r_ovf = 1'b0; r_err = 1'b1;
         lat   = 1;
      end else begin
         va    = sa ? -bcd2int(a) : bcd2int(a);
         vb    = sb ? -bcd2int(b) : bcd2int(b);
         r     = op ? (va - vb) : (va + vb);
         s     = (r < 0) ? -r : r;
         mag   = s % 1000;
         r_bcd = int2bcd(mag);
         r_sign = (r < 0) && (mag != 0);
         r_ovf = (s > 999);
         r_err = 1'b0;
         lat   = (r_eff && bcd2int(a) < bcd2int(b)) ? 2 * NDIG + 1 : NDIG + 1;
      end

      bus.op = op; bus.sign_a = sa; bus.a_bcd = a; bus.sign_b = sb; bus.b_bcd = b;
      bus.start = 1'b1;
      while (edges - t0 < lat + 1) begin
         @(negedge clk);
         bus.start = 1'b0;
         rst       = 1'b0;
         if (rst_e > 0 && edges - t0 == rst_e) begin
            rst    = 1'b1;
            rst_at = edges + 1;
         end else if (rst_at > 0) begin
            if (edges >= rst_at + 2) break;
         end else if (poke && (edges - t0 == 3 || edges - t0 == lat)) begin
            bus.start = 1'b1;
            bus.a_bcd = 12'h999;
            bus.op    = ~op;
         end
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.op = 1'b0; bus.sign_a = 1'b0; bus.sign_b = 1'b0;
      bus.a_bcd = '0;   bus.b_bcd = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      run_op(1'b0, 1'b0, 12'h123, 1'b0, 12'h456, 1'b0, 0);
      chk("lit1_res", 32'(bus.res_bcd), 32'h579);
      chk("lit1_lat", 32'(lat), 32'd4);

      run_op(1'b1, 1'b0, 12'h123, 1'b0, 12'h456, 1'b1, 0);
      chk("lit2_res", 32'(bus.res_bcd), 32'h333);
      chk("lit2_sign", 32'(bus.res_sign), 32'd1);
      chk("lit2_lat", 32'(lat), 32'd7);
`ifdef BCD_ADDSUB_SEQ_LED_EN
      chk("lit2_seg", 32'(seg), {4'h0, 7'b0000001, 7'h79, 7'h79, 7'h79});
`endif

      run_op(1'b0, 1'b0, 12'h999, 1'b0, 12'h001, 1'b0, 0);
      chk("lit3_res", 32'(bus.res_bcd), 32'h000);
      chk("lit3_ovf", 32'(bus.ovf), 32'd1);

      run_op(1'b1, 1'b1, 12'h250, 1'b1, 12'h250, 1'b0, 0);
      chk("lit4_sign", 32'(bus.res_sign), 32'd0);
      chk("lit4_ovf", 32'(bus.ovf), 32'd0);

      run_op(1'b0, 1'b0, 12'h1A3, 1'b0, 12'h001, 1'b0, 0);
      chk("lit5_err", 32'(bus.err), 32'd1);

      run_op(1'b1, 1'b0, 12'h123, 1'b0, 12'h456, 1'b0, 2);
      chk("lit6_busy", 32'(bus.busy), 32'd0);

      run_op(1'b0, 1'b0, 12'h123, 1'b0, 12'h456, 1'b0, 0);
      run_op(1'b0, 1'b1, 12'h005, 1'b0, 12'h003, 1'b0, 0);
      chk("lit7_res", 32'(bus.res_bcd), 32'h002);
      chk("lit7_sign", 32'(bus.res_sign), 32'd1);
      run_op(1'b1, 1'b0, 12'h003, 1'b1, 12'h007, 1'b0, 0);
      chk("lit8_res", 32'(bus.res_bcd), 32'h010);
      run_op(1'b0, 1'b1, 12'h100, 1'b0, 12'h300, 1'b0, 0);
      chk("lit9_res", 32'(bus.res_bcd), 32'h200);
      chk("lit9_sign", 32'(bus.res_sign), 32'd0);
      run_op(1'b0, 1'b1, 12'h678, 1'b1, 12'h456, 1'b0, 0);
      chk("lit10_res", 32'(bus.res_bcd), 32'h134);
      chk("lit10_sign", 32'(bus.res_sign), 32'd1);
      chk("lit10_ovf", 32'(bus.ovf), 32'd1);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end
endmodule
